// File: rtl/synth_pkg.sv
// synth_pkg: shared definitions for the polyphonic synth voice engine.
//   - default parameter constants for synth_poly
//   - envelope state encoding used by synth_poly_env
//   - sat_add8: 8-bit add that saturates at 255
package synth_pkg;

  localparam int DEF_NVOICE     = 4;
  localparam int DEF_OSC_W      = 12;
  localparam int DEF_SAMPLE_DIV = 512;
  localparam int DEF_ENV_DIV    = 512;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/synth_poly_if.sv
// synth_poly_if: groups the control inputs and audio outputs of synth_poly.
//   master : the controller side (drives gates, pitches, ADSR settings)
//   slave  : the synth side (drives sample, sample_valid, voice_active)
// Parameters match synth_poly: NVOICE voices, OSC_W-bit oscillator periods.
interface synth_poly_if #(
  parameter int NVOICE = synth_pkg::DEF_NVOICE,
  parameter int OSC_W  = synth_pkg::DEF_OSC_W
);
  logic [NVOICE-1:0]       trig;
  logic [NVOICE*OSC_W-1:0] osc_count;
  logic [7:0]              adsr_ai;
  logic [7:0]              adsr_di;
  logic [7:0]              adsr_s;
  logic [7:0]              adsr_ri;
  logic [15:0]             sample;
  logic                    sample_valid;
  logic [NVOICE-1:0]       voice_active;

  modport master (
    output trig, osc_count, adsr_ai, adsr_di, adsr_s, adsr_ri,
    input  sample, sample_valid, voice_active
  );

  modport slave (
    input  trig, osc_count, adsr_ai, adsr_di, adsr_s, adsr_ri,
    output sample, sample_valid, voice_active
  );
endinterface

// File: rtl/synth_poly_env.sv
// synth_poly_env: one voice's ADSR envelope generator.
//   clk, rstn  : clock, asynchronous active-low reset
//   env_tick   : one-cycle enable; state and level only change on it
//   rise_flag  : sticky "gate went high" flag, forces (re)entry to ATTACK
//   gate       : synchronised gate level; low releases the voice
//   ai/di/s/ri : attack increment, decay decrement, sustain level, release decrement
//   env        : 8-bit envelope level
//   active     : high whenever the envelope is not IDLE
module synth_poly_env
  import synth_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       env_tick,
  input  logic       rise_flag,
  input  logic       gate,
  input  logic [7:0] ai,
  input  logic [7:0] di,
  input  logic [7:0] s,
  input  logic [7:0] ri,
  output logic [7:0] env,
  output logic       active
);

  env_state_e state_q, state_d;
  logic [7:0] env_q, env_d;
  logic [7:0] att_sum;

  assign att_sum = sat_add8(env_q, ai);

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (env_tick) begin
      if (rise_flag) begin
        // Retrigger keeps the present level so a re-struck note does not click.
        state_d = ENV_ATTACK;
      end else begin
        unique case (state_q)
          ENV_IDLE: begin
            env_d = 8'h00;
          end
          ENV_ATTACK: begin
            if (!gate) begin
              state_d = ENV_RELEASE;
            end else if (ai == 8'h00 || att_sum == 8'hFF) begin
              env_d   = 8'hFF;
              state_d = ENV_DECAY;
            end else begin
              env_d = att_sum;
            end
          end
          ENV_DECAY: begin
            if (!gate) begin
              state_d = ENV_RELEASE;
            end else if (s == 8'hFF || di == 8'h00) begin
              state_d = ENV_SUSTAIN;
            end else if (env_q <= di || (env_q - di) <= s) begin
              env_d   = s;
              state_d = ENV_SUSTAIN;
            end else begin
              env_d = env_q - di;
            end
          end
          ENV_SUSTAIN: begin
            if (!gate) begin
              state_d = ENV_RELEASE;
            end else begin
              env_d = s;
            end
          end
          ENV_RELEASE: begin
            if (ri == 8'h00 || env_q <= ri) begin
              env_d   = 8'h00;
              state_d = ENV_IDLE;
            end else begin
              env_d = env_q - ri;
            end
          end
          default: begin
            env_d   = 8'h00;
            state_d = ENV_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ENV_IDLE;
      env_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  assign env    = env_q;
  assign active = (state_q != ENV_IDLE);

endmodule

// File: rtl/synth_poly.sv
// synth_poly: NVOICE-voice square-wave synthesiser with per-voice ADSR.
//   clk, rstn    : clock, asynchronous active-low reset
//   trig         : per-voice gate (asynchronous, synchronised here)
//   osc_count    : per-voice half-period in sample ticks minus 1 (0 = silent)
//   adsr_*       : envelope settings shared by all voices
//   sample       : mixed output, updated once per sample tick
//   sample_valid : one-cycle strobe, NVOICE+1 cycles after the sample tick
//   voice_active : per-voice "envelope not IDLE"
module synth_poly
  import synth_pkg::*;
#(
  parameter int NVOICE     = DEF_NVOICE,
  parameter int OSC_W      = DEF_OSC_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int ENV_DIV    = DEF_ENV_DIV
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NVOICE-1:0]       trig,
  input  logic [NVOICE*OSC_W-1:0] osc_count,
  input  logic [7:0]              adsr_ai,
  input  logic [7:0]              adsr_di,
  input  logic [7:0]              adsr_s,
  input  logic [7:0]              adsr_ri,
  output logic [15:0]             sample,
  output logic                    sample_valid,
  output logic [NVOICE-1:0]       voice_active
);

  localparam int SHIFT = $clog2(NVOICE);
  localparam int ACC_W = 16 + SHIFT;
  localparam int IDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int SC_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int EC_W  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  // Tick generation: both rates come from free-running counters as enables.
  logic [SC_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [EC_W-1:0] env_cnt_q, env_cnt_d;
  logic sample_tick, env_tick;

  assign sample_tick = (smp_cnt_q == SC_W'(SAMPLE_DIV - 1));
  assign env_tick    = sample_tick && (env_cnt_q == EC_W'(ENV_DIV - 1));

  // Gate synchroniser; s3 is only the previous s2 for edge detection.
  logic [NVOICE-1:0] trig_s1_q, trig_s2_q, trig_s3_q;
  logic [NVOICE-1:0] rise_flag_q, rise_flag_d;

  // MAC datapath
  logic [NVOICE-1:0]   osc_bits;
  logic [NVOICE*8-1:0] env_all;
  logic [NVOICE-1:0]   osc_snap_q, osc_snap_d;
  logic [NVOICE*8-1:0] env_snap_q, env_snap_d;
  logic                mac_busy_q, mac_busy_d;
  logic                mac_done_q, mac_done_d;
  logic [IDX_W-1:0]    mac_idx_q, mac_idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [15:0]         sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic [7:0]          mac_osc, mac_env;
  logic [15:0]         mac_prod;

  assign mac_osc  = osc_snap_q[mac_idx_q] ? 8'hFF : 8'h00;
  assign mac_env  = env_snap_q[{mac_idx_q, 3'b000} +: 8];
  assign mac_prod = mac_osc * mac_env;

  always_comb begin
    smp_cnt_d = sample_tick ? '0 : smp_cnt_q + 1'b1;
    env_cnt_d = env_cnt_q;
    if (sample_tick) begin
      env_cnt_d = (env_cnt_q == EC_W'(ENV_DIV - 1)) ? '0 : env_cnt_q + 1'b1;
    end
    // A rise in the same cycle as the clearing tick is kept for the next tick.
    rise_flag_d = (env_tick ? '0 : rise_flag_q) | (trig_s2_q & ~trig_s3_q);
  end

  always_comb begin
    osc_snap_d     = osc_snap_q;
    env_snap_d     = env_snap_q;
    mac_busy_d     = mac_busy_q;
    mac_done_d     = 1'b0;
    mac_idx_d      = mac_idx_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (mac_busy_q) begin
      acc_d     = acc_q + ACC_W'(mac_prod);
      mac_idx_d = mac_idx_q + 1'b1;
      if (mac_idx_q == IDX_W'(NVOICE - 1)) begin
        mac_busy_d = 1'b0;
        mac_done_d = 1'b1;
      end
    end
    if (mac_done_q) begin
      sample_d       = 16'(acc_q >> SHIFT);
      sample_valid_d = 1'b1;
    end
    // Freeze the voice values seen at the tick so envelope updates landing
    // during the MAC cannot tear the sample.
    if (sample_tick) begin
      osc_snap_d = osc_bits;
      env_snap_d = env_all;
      acc_d      = '0;
      mac_idx_d  = '0;
      mac_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_cnt_q      <= '0;
      env_cnt_q      <= '0;
      trig_s1_q      <= '0;
      trig_s2_q      <= '0;
      trig_s3_q      <= '0;
      rise_flag_q    <= '0;
      osc_snap_q     <= '0;
      env_snap_q     <= '0;
      mac_busy_q     <= 1'b0;
      mac_done_q     <= 1'b0;
      mac_idx_q      <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      smp_cnt_q      <= smp_cnt_d;
      env_cnt_q      <= env_cnt_d;
      trig_s1_q      <= trig;
      trig_s2_q      <= trig_s1_q;
      trig_s3_q      <= trig_s2_q;
      rise_flag_q    <= rise_flag_d;
      osc_snap_q     <= osc_snap_d;
      env_snap_q     <= env_snap_d;
      mac_busy_q     <= mac_busy_d;
      mac_done_q     <= mac_done_d;
      mac_idx_q      <= mac_idx_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
    logic [OSC_W-1:0] period;
    logic [OSC_W-1:0] osc_cnt_q, osc_cnt_d;
    logic             osc_out_q, osc_out_d;

    assign period = osc_count[gi*OSC_W +: OSC_W];

    always_comb begin
      osc_cnt_d = osc_cnt_q;
      osc_out_d = osc_out_q;
      if (sample_tick) begin
        if (period == '0) begin
          osc_cnt_d = '0;
          osc_out_d = 1'b0;
        end else if (osc_cnt_q == period) begin
          osc_cnt_d = '0;
          osc_out_d = ~osc_out_q;
        end else begin
          osc_cnt_d = osc_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        osc_cnt_q <= '0;
        osc_out_q <= 1'b0;
      end else begin
        osc_cnt_q <= osc_cnt_d;
        osc_out_q <= osc_out_d;
      end
    end

    assign osc_bits[gi] = osc_out_q;

    synth_poly_env u_env (
      .clk       (clk),
      .rstn      (rstn),
      .env_tick  (env_tick),
      .rise_flag (rise_flag_q[gi]),
      .gate      (trig_s2_q[gi]),
      .ai        (adsr_ai),
      .di        (adsr_di),
      .s         (adsr_s),
      .ri        (adsr_ri),
      .env       (env_all[gi*8 +: 8]),
      .active    (voice_active[gi])
    );
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: doc/synth_poly.md
SYNTH_POLY -- requirements
Module: synth_poly

Interface
REQ-001 SHALL have parameter NVOICE, default 4: number of independent voices, 1..8.
REQ-002 SHALL have parameter OSC_W, default 12: width of the per-voice oscillator period count.
REQ-003 SHALL have parameter SAMPLE_DIV, default 512: clk cycles per sample tick; must be at least NVOICE+2.
REQ-004 SHALL have parameter ENV_DIV, default 512: sample ticks per envelope tick.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic (20.48 MHz nominal).
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port trig, input, NVOICE bits: per-voice gate, asynchronous to clk.
REQ-008 SHALL have port osc_count, input, NVOICE*OSC_W bits: per-voice half-period in sample ticks minus 1; voice v uses bits [v*OSC_W +: OSC_W].
REQ-009 SHALL have ports adsr_ai, adsr_di, adsr_s, adsr_ri, input, 8 bits each: attack increment, decay decrement, sustain level and release decrement, shared by all voices.
REQ-010 SHALL have port sample, output, 16 bits: mixed output sample.
REQ-011 SHALL have port sample_valid, output, 1 bit: one-cycle strobe marking a new sample.
REQ-012 SHALL have port voice_active, output, NVOICE bits: set while the voice envelope is not IDLE.

Function
REQ-013 SHALL derive a sample tick (one-cycle enable) every SAMPLE_DIV clk cycles and an envelope tick every ENV_DIV sample ticks, both from free-running counters; no derived clocks.
REQ-014 SHALL pass each trig bit through a 2-flop synchroniser and latch a sticky rising-edge flag, cleared at the next envelope tick, so gate pulses shorter than one envelope period are not lost.
REQ-015 SHALL give each voice a square oscillator: counter advances on each sample tick; on reaching osc_count it clears and the output toggles between 8'h00 and 8'hFF; osc_count=0 forces the output to 8'h00.
REQ-016 SHALL give each voice an envelope FSM with states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, updated only on envelope ticks; env is 8 bits.
REQ-017 Any state with the rising-edge flag set SHALL go to ATTACK, retaining the current env (retrigger, no reset to 0).
REQ-018 ATTACK SHALL add ai, saturating at 255; on reaching 255 go to DECAY; ai=0 jumps directly to 255.
REQ-019 DECAY SHALL subtract di, clamping at s; on reaching s go to SUSTAIN; s>=255 or di=0 goes to SUSTAIN at the current env.
REQ-020 SUSTAIN SHALL hold env=s, tracking s changes.
REQ-021 With synchronised trig low in ATTACK, DECAY or SUSTAIN, the voice SHALL go to RELEASE; a set rising-edge flag takes priority.
REQ-022 RELEASE SHALL subtract ri, clamping at 0, and go to IDLE at 0; ri=0 sets env=0 and goes to IDLE.
REQ-023 On each sample tick SHALL run a sequential MAC, one voice per clk cycle: acc += osc_v*env_v (16-bit product), accumulator width 16+clog2(NVOICE).
REQ-024 SHALL register sample = acc >> clog2(NVOICE) and pulse sample_valid exactly NVOICE+1 clk cycles after the sample tick; sample holds until the next update.
REQ-025 Oscillator and envelope values SHALL be snapshotted at the sample tick, so an envelope update during the MAC does not affect the sample in progress.

Reset
REQ-026 While rstn is low, all counters, synchronisers, flags, env values and oscillators SHALL be 0, all FSMs IDLE, sample=0, sample_valid=0 and voice_active=0, immediately and asynchronously.
REQ-027 Reset asserted mid-MAC or mid-envelope SHALL abort the operation, and no sample_valid SHALL follow; after release, the first sample tick occurs SAMPLE_DIV cycles later.

Structure
REQ-028 Package synth_pkg SHALL hold the envelope state enum and the default parameter constants.
REQ-029 The per-voice envelope FSM SHALL be a sub-module synth_poly_env, instantiated NVOICE times via generate.

Verification (NVOICE=4, SAMPLE_DIV=16, ENV_DIV=2)
REQ-030 Reset: rstn low then released -> sample=0, voice_active=0, first sample_valid at cycle 16+5.
REQ-031 Attack/decay: ai=64, di=16, s=200, trig[0] held -> env0 sequence 64,128,192,255,239,223,207,200, then SUSTAIN.
REQ-032 Release: trig[0] dropped in SUSTAIN with ri=100 -> env0 100, 0, IDLE, voice_active[0]=0.
REQ-033 Mix: all voices osc 8'hFF and env 255 -> sample=65025; only voice 0 active -> sample=16256.
REQ-034 Oscillator: osc_count[0]=3 -> voice 0 output high for 4 sample ticks and low for 4; osc_count=0 -> contributes 0.
REQ-035 Short gate: 1-cycle trig[1] pulse between envelope ticks -> ATTACK entered at the next tick, then RELEASE at the following tick.
